lcd_pixel_stream_arbiter: RTL and testbench

//   Packet-level round-robin arbiter sharing the LCD pixel FIFO write port between two Avalon-ST

---
 rtl/lcd_pixel_arb_pkg.sv | 18 +
 rtl/lcd_st_pipe_reg.sv | 43 ++++
 rtl/lcd_pixel_stream_arbiter.sv | 161 ++++++++++++++++
 tb/tb_lcd_pixel_stream_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pixel_arb_pkg.sv
// Shared types and defaults for the two-source LCD pixel stream arbiter.
package lcd_pixel_arb_pkg;

   localparam int DATA_W  = 64;
   localparam int EMPTY_W = 3;
   localparam int CNT_W   = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arb_state_t;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_0    = 2'b01;
   localparam logic [1:0] GNT_1    = 2'b10;

endpackage

// File: rtl/lcd_st_pipe_reg.sv
// Single-stage Avalon-ST register slice: holds a beat stable until the sink takes it,
// and accepts a new beat in the same cycle the held one drains.
module lcd_st_pipe_reg #(
   parameter int DATA_W  = lcd_pixel_arb_pkg::DATA_W,
   parameter int EMPTY_W = lcd_pixel_arb_pkg::EMPTY_W
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [EMPTY_W-1:0] in_empty,
   input  logic               in_sop,
   input  logic               in_eop,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [EMPTY_W-1:0] out_empty,
   output logic               out_sop,
   output logic               out_eop
);

   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_empty <= '0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
      end else if (in_valid && in_ready) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
         out_empty <= in_empty;
         out_sop   <= in_sop;
         out_eop   <= in_eop;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/lcd_pixel_stream_arbiter.sv
// Packet-level round-robin arbiter feeding the LCD pixel FIFO from two Avalon-ST sources.
// Define LCD_PIXEL_ARB_STATS_EN to build the per-source completed-packet counters.
module lcd_pixel_stream_arbiter #(
   parameter int DATA_W  = lcd_pixel_arb_pkg::DATA_W,
   parameter int EMPTY_W = lcd_pixel_arb_pkg::EMPTY_W,
   parameter int CNT_W   = lcd_pixel_arb_pkg::CNT_W
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic [DATA_W-1:0]  in0_data,
   input  logic [EMPTY_W-1:0] in0_empty,
   input  logic               in0_sop,
   input  logic               in0_eop,
   input  logic               in0_valid,
   output logic               in0_ready,
   input  logic [DATA_W-1:0]  in1_data,
   input  logic [EMPTY_W-1:0] in1_empty,
   input  logic               in1_sop,
   input  logic               in1_eop,
   input  logic               in1_valid,
   output logic               in1_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [EMPTY_W-1:0] out_empty,
   output logic               out_sop,
   output logic               out_eop,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [1:0]         grant,
   output logic               drop_pulse,
   output logic [CNT_W-1:0]   pkt_cnt0,
   output logic [CNT_W-1:0]   pkt_cnt1
);

   import lcd_pixel_arb_pkg::*;

   arb_state_t         state;
   logic               rr_last;
   logic               sel_valid;
   logic [DATA_W-1:0]  sel_data;
   logic [EMPTY_W-1:0] sel_empty;
   logic               sel_sop;
   logic               sel_eop;
   logic               pipe_ready;
   logic               acc_eop;
   logic               req0;
   logic               req1;
   logic               orphan0;
   logic               orphan1;

   always_comb begin
      sel_valid = 1'b0;
      sel_data  = in0_data;
      sel_empty = in0_empty;
      sel_sop   = in0_sop;
      sel_eop   = in0_eop;
      case (state)
         GRANT0: sel_valid = in0_valid;
         GRANT1: begin
            sel_valid = in1_valid;
            sel_data  = in1_data;
            sel_empty = in1_empty;
            sel_sop   = in1_sop;
            sel_eop   = in1_eop;
         end
         default: sel_valid = 1'b0;
      endcase
   end

   // In IDLE a sop beat waits for its grant; anything else is a stray tail beat and is flushed.
   assign orphan0 = (state == IDLE) && in0_valid && !in0_sop;
   assign orphan1 = (state == IDLE) && in1_valid && !in1_sop;
   assign req0    = enable && in0_valid && in0_sop;
   assign req1    = enable && in1_valid && in1_sop;

   assign in0_ready = (state == GRANT0) ? pipe_ready : orphan0;
   assign in1_ready = (state == GRANT1) ? pipe_ready : orphan1;
   assign acc_eop   = sel_valid && pipe_ready && sel_eop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         grant      <= GNT_NONE;
         rr_last    <= 1'b1;
         drop_pulse <= 1'b0;
      end else begin
         drop_pulse <= orphan0 || orphan1;
         case (state)
            IDLE: begin
               if (req0 && (!req1 || rr_last)) begin
                  state <= GRANT0;
                  grant <= GNT_0;
               end else if (req1) begin
                  state <= GRANT1;
                  grant <= GNT_1;
               end
            end
            GRANT0: begin
               if (acc_eop) begin
                  state   <= IDLE;
                  grant   <= GNT_NONE;
                  rr_last <= 1'b0;
               end
            end
            GRANT1: begin
               if (acc_eop) begin
                  state   <= IDLE;
                  grant   <= GNT_NONE;
                  rr_last <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               grant <= GNT_NONE;
            end
         endcase
      end
   end

   lcd_st_pipe_reg #(
      .DATA_W  (DATA_W),
      .EMPTY_W (EMPTY_W)
   ) u_out_reg (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (sel_valid),
      .in_ready  (pipe_ready),
      .in_data   (sel_data),
      .in_empty  (sel_empty),
      .in_sop    (sel_sop),
      .in_eop    (sel_eop),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_empty (out_empty),
      .out_sop   (out_sop),
      .out_eop   (out_eop)
   );

`ifdef LCD_PIXEL_ARB_STATS_EN
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else if (acc_eop) begin
         if (state == GRANT0) cnt0 <= cnt0 + 1'b1;
         if (state == GRANT1) cnt1 <= cnt1 + 1'b1;
      end
   end

   assign pkt_cnt0 = cnt0;
   assign pkt_cnt1 = cnt1;
`else
   assign pkt_cnt0 = '0;
   assign pkt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_lcd_pixel_stream_arbiter.sv
// Bench for lcd_pixel_stream_arbiter: cycle table for the basic sequences, then queue-driven
// sources checked by a packet-level scoreboard (order, contiguity, stall hold, counters).
module tb_lcd_pixel_stream_arbiter;

   localparam int DW = 64;
   localparam int EW = 3;
   localparam int CW = 8;
`ifdef LCD_PIXEL_ARB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic          enable;
   logic [DW-1:0] in0_data, in1_data;
   logic [EW-1:0] in0_empty, in1_empty;
   logic          in0_sop, in0_eop, in0_valid, in0_ready;
   logic          in1_sop, in1_eop, in1_valid, in1_ready;
   logic [DW-1:0] out_data;
   logic [EW-1:0] out_empty;
   logic          out_sop, out_eop, out_valid, out_ready;
   logic [1:0]    grant;
   logic          drop_pulse;
   logic [CW-1:0] pkt_cnt0, pkt_cnt1;

   always #5 clk = ~clk;

   lcd_pixel_stream_arbiter #(.DATA_W(DW), .EMPTY_W(EW), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .in0_data(in0_data), .in0_empty(in0_empty), .in0_sop(in0_sop), .in0_eop(in0_eop),
      .in0_valid(in0_valid), .in0_ready(in0_ready),
      .in1_data(in1_data), .in1_empty(in1_empty), .in1_sop(in1_sop), .in1_eop(in1_eop),
      .in1_valid(in1_valid), .in1_ready(in1_ready),
      .out_data(out_data), .out_empty(out_empty), .out_sop(out_sop), .out_eop(out_eop),
      .out_valid(out_valid), .out_ready(out_ready),
      .grant(grant), .drop_pulse(drop_pulse), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s: cycle budget expired", name);
   endtask

   // ---------------- cycle table ----------------
   typedef struct {
      logic en, v0, s0, e0; logic [DW-1:0] d0;
      logic v1, s1, e1;     logic [DW-1:0] d1;
      logic ordy;
      logic xv; logic [DW-1:0] xd; logic xs, xe;
      logic [1:0] xg; logic xr0, xr1, xdrop;
   } vec_t;

   function automatic vec_t mk(input logic en, v0, s0, e0, input logic [DW-1:0] d0,
                               input logic v1, s1, e1, input logic [DW-1:0] d1,
                               input logic xv, input logic [DW-1:0] xd, input logic xs, xe,
                               input logic [1:0] xg, input logic xr0, xr1, xdrop);
      vec_t v;
      v.en = en; v.v0 = v0; v.s0 = s0; v.e0 = e0; v.d0 = d0;
      v.v1 = v1; v.s1 = s1; v.e1 = e1; v.d1 = d1; v.ordy = 1'b1;
      v.xv = xv; v.xd = xd; v.xs = xs; v.xe = xe;
      v.xg = xg; v.xr0 = xr0; v.xr1 = xr1; v.xdrop = xdrop;
      return v;
   endfunction

   vec_t vt[20];

   // ---------------- queue-driven sources and scoreboard ----------------
   typedef struct packed {
      logic [DW-1:0] d; logic [EW-1:0] e; logic s; logic eo;
   } beat_t;

   beat_t q0[$], q1[$], x0[$], x1[$];
   int    sop_log[$];
   int    cnt_m[2];
   int    cur_src, pkt_seq, or_mode, n_out;
   bit    gap_en, en_rand, en_val, acc0, acc1, stall_prev;
   logic [DW-1:0] held_d;

   task automatic gen_pkt(input int src, input int len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.d  = {8'(src), 24'(pkt_seq), 32'(i)};
         b.e  = EW'($urandom_range(0, 7));
         b.s  = (i == 0);
         b.eo = (i == len - 1);
         if (src == 0) begin q0.push_back(b); x0.push_back(b); end
         else          begin q1.push_back(b); x1.push_back(b); end
      end
      pkt_seq++;
   endtask

   function automatic logic [CW-1:0] exp_cnt(input int k);
      return STATS ? CW'(cnt_m[k]) : '0;
   endfunction

   task automatic score(input beat_t b);
      int    src;
      beat_t e;
      src = int'(b.d[63:56]);
      if (src > 1) begin
         chk("out_src_tag", b.d[63:56], 0);
         return;
      end
      if (b.s) begin
         chk("sop_between_pkts", cur_src, -1);
         cur_src = src;
         sop_log.push_back(src);
      end else begin
         chk("beat_src_contig", src, cur_src);
      end
      if ((src == 0 && x0.size() == 0) || (src == 1 && x1.size() == 0)) begin
         chk("unexpected_beat", b, 0);
         return;
      end
      e = (src == 0) ? x0.pop_front() : x1.pop_front();
      chk("out_beat", b, e);
      if (b.eo) cur_src = -1;
   endtask

   task automatic tick();
      @(negedge clk);
      if (acc0) begin void'(q0.pop_front()); in0_valid = 1'b0; end
      if (acc1) begin void'(q1.pop_front()); in1_valid = 1'b0; end
      if (!in0_valid && q0.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
         in0_valid = 1'b1; in0_data = q0[0].d; in0_empty = q0[0].e;
         in0_sop = q0[0].s; in0_eop = q0[0].eo;
      end
      if (!in1_valid && q1.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
         in1_valid = 1'b1; in1_data = q1[0].d; in1_empty = q1[0].e;
         in1_sop = q1[0].s; in1_eop = q1[0].eo;
      end
      case (or_mode)
         1:       out_ready = ($urandom_range(0, 3) != 0);
         2:       out_ready = ~out_ready;
         default: out_ready = 1'b1;
      endcase
      enable = en_rand ? ($urandom_range(0, 7) != 0) : en_val;
      #1;
      acc0 = in0_valid && in0_ready;
      acc1 = in1_valid && in1_ready;
      if (acc0 && in0_eop) cnt_m[0]++;
      if (acc1 && in1_eop) cnt_m[1]++;
      if (stall_prev) begin
         chk("stall_hold_valid", out_valid, 1);
         chk("stall_hold_data", out_data, held_d);
      end
      if (out_valid && !out_ready) chk("src_ready_low_on_stall", in0_ready || in1_ready, 0);
      if (grant == 2'b01) chk("other_ready_low_g0", in1_ready, 0);
      if (grant == 2'b10) chk("other_ready_low_g1", in0_ready, 0);
      stall_prev = out_valid && !out_ready;
      held_d     = out_data;
      if (out_valid && out_ready) begin
         score({out_data, out_empty, out_sop, out_eop});
         n_out++;
      end
   endtask

   task automatic run_until_done(input string name, input int budget);
      int n;
      n = 0;
      while (!(q0.size() == 0 && q1.size() == 0 && x0.size() == 0 && x1.size() == 0
               && !out_valid && !in0_valid && !in1_valid)) begin
         if (n >= budget) begin timeout(name); return; end
         tick();
         n++;
      end
   endtask

   task automatic clear_tb();
      q0.delete(); q1.delete(); x0.delete(); x1.delete(); sop_log.delete();
      in0_valid = 0; in0_sop = 0; in0_eop = 0; in0_data = '0; in0_empty = '0;
      in1_valid = 0; in1_sop = 0; in1_eop = 0; in1_data = '0; in1_empty = '0;
      cnt_m[0] = 0; cnt_m[1] = 0; cur_src = -1; n_out = 0;
      acc0 = 0; acc1 = 0; stall_prev = 0;
      gap_en = 0; en_rand = 0; en_val = 1; or_mode = 0;
      enable = 1; out_ready = 1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      clear_tb();
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_grant", grant, 0);
      chk("rst_drop", drop_pulse, 0);
      chk("rst_cnt0", pkt_cnt0, 0);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      clear_tb();
      do_reset();

      // single 4-beat packet from in0, orphan flushing, enable gating of a pending sop
      vt[0]  = mk(1, 1,1,0, 64'hA0, 0,0,0, 0,  0, 0,    0,0, 2'b00, 0,0, 0);
      vt[1]  = mk(1, 1,1,0, 64'hA0, 0,0,0, 0,  0, 0,    0,0, 2'b01, 1,0, 0);
      vt[2]  = mk(1, 1,0,0, 64'hA1, 0,0,0, 0,  1, 64'hA0, 1,0, 2'b01, 1,0, 0);
      vt[3]  = mk(1, 1,0,0, 64'hA2, 0,0,0, 0,  1, 64'hA1, 0,0, 2'b01, 1,0, 0);
      vt[4]  = mk(1, 1,0,1, 64'hA3, 0,0,0, 0,  1, 64'hA2, 0,0, 2'b01, 1,0, 0);
      vt[5]  = mk(1, 0,0,0, 0,      0,0,0, 0,  1, 64'hA3, 0,1, 2'b00, 0,0, 0);
      vt[6]  = mk(1, 0,0,0, 0,      0,0,0, 0,  0, 0,    0,0, 2'b00, 0,0, 0);
      vt[7]  = mk(1, 1,0,0, 64'hB0, 0,0,0, 0,  0, 0,    0,0, 2'b00, 1,0, 0);
      vt[8]  = mk(1, 1,0,0, 64'hB1, 0,0,0, 0,  0, 0,    0,0, 2'b00, 1,0, 1);
      vt[9]  = mk(1, 0,0,0, 0,      0,0,0, 0,  0, 0,    0,0, 2'b00, 0,0, 1);
      vt[10] = mk(1, 1,0,0, 64'hB2, 1,0,0, 64'hB3, 0, 0, 0,0, 2'b00, 1,1, 0);
      vt[11] = mk(1, 0,0,0, 0,      0,0,0, 0,  0, 0,    0,0, 2'b00, 0,0, 1);
      vt[12] = mk(1, 0,0,0, 0,      0,0,0, 0,  0, 0,    0,0, 2'b00, 0,0, 0);
      vt[13] = mk(0, 0,0,0, 0,      1,1,0, 64'hC0, 0, 0, 0,0, 2'b00, 0,0, 0);
      vt[14] = mk(0, 0,0,0, 0,      1,1,0, 64'hC0, 0, 0, 0,0, 2'b00, 0,0, 0);
      vt[15] = mk(1, 0,0,0, 0,      1,1,0, 64'hC0, 0, 0, 0,0, 2'b00, 0,0, 0);
      vt[16] = mk(1, 0,0,0, 0,      1,1,0, 64'hC0, 0, 0, 0,0, 2'b10, 0,1, 0);
      vt[17] = mk(1, 0,0,0, 0,      1,0,1, 64'hC1, 1, 64'hC0, 1,0, 2'b10, 0,1, 0);
      vt[18] = mk(1, 0,0,0, 0,      0,0,0, 0,  1, 64'hC1, 0,1, 2'b00, 0,0, 0);
      vt[19] = mk(1, 0,0,0, 0,      0,0,0, 0,  0, 0,    0,0, 2'b00, 0,0, 0);

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         enable = vt[i].en; out_ready = vt[i].ordy;
         in0_valid = vt[i].v0; in0_sop = vt[i].s0; in0_eop = vt[i].e0; in0_data = vt[i].d0;
         in1_valid = vt[i].v1; in1_sop = vt[i].s1; in1_eop = vt[i].e1; in1_data = vt[i].d1;
         #1;
         chk($sformatf("vec%0d_out_valid", i), out_valid, vt[i].xv);
         chk($sformatf("vec%0d_grant", i), grant, vt[i].xg);
         chk($sformatf("vec%0d_in0_ready", i), in0_ready, vt[i].xr0);
         chk($sformatf("vec%0d_in1_ready", i), in1_ready, vt[i].xr1);
         chk($sformatf("vec%0d_drop", i), drop_pulse, vt[i].xdrop);
         if (vt[i].xv) begin
            chk($sformatf("vec%0d_out_data", i), out_data, vt[i].xd);
            chk($sformatf("vec%0d_out_sop", i), out_sop, vt[i].xs);
            chk($sformatf("vec%0d_out_eop", i), out_eop, vt[i].xe);
         end
         if (i == 5)  chk("vec_pkt_cnt0", pkt_cnt0, STATS ? CW'(1) : CW'(0));
         if (i == 18) chk("vec_pkt_cnt1", pkt_cnt1, STATS ? CW'(1) : CW'(0));
      end

      // both sources request together: strict alternation starting with in0
      do_reset();
      gen_pkt(0, 3); gen_pkt(0, 2);
      gen_pkt(1, 2); gen_pkt(1, 3);
      run_until_done("rr_drain", 200);
      chk("rr_pkt_count", sop_log.size(), 4);
      for (int i = 0; i < 4 && i < sop_log.size(); i++)
         chk($sformatf("rr_order%0d", i), sop_log[i], i % 2);
      chk("rr_cnt0", pkt_cnt0, exp_cnt(0));
      chk("rr_cnt1", pkt_cnt1, exp_cnt(1));

      // back-pressure toggling 1010 during an in1 packet
      do_reset();
      or_mode = 2;
      gen_pkt(1, 3);
      run_until_done("toggle_drain", 100);
      chk("toggle_beats", n_out, 3);

      // enable dropped mid-packet of in1 with in0 waiting
      do_reset();
      gen_pkt(1, 4);
      begin
         int n;
         n = 0;
         while (!acc1 && n < 20) begin tick(); n++; end
         if (!acc1) timeout("en_first_beat");
         en_val = 0;
         gen_pkt(0, 2);
         n = 0;
         while (x1.size() > 0 && n < 40) begin tick(); n++; end
         if (x1.size() > 0) timeout("en_in1_finish");
         repeat (3) begin
            tick();
            chk("en_no_grant", grant, 0);
            chk("en_in0_not_ready", in0_ready, 0);
         end
         en_val = 1;
         tick();
         chk("en_grant_wait", grant, 0);
         tick();
         chk("en_grant_next", grant, 2'b01);
      end
      run_until_done("en_drain", 100);
      chk("en_sop_log", sop_log.size(), 2);

      // reset in the middle of a packet
      do_reset();
      gen_pkt(1, 1);
      gen_pkt(0, 4);
      begin
         int n;
         n = 0;
         while (n_out < 3 && n < 40) begin tick(); n++; end
         if (n_out < 3) timeout("rst_mid_reach");
      end
      chk("rst_mid_cnt1_before", pkt_cnt1, exp_cnt(1));
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", out_valid, 0);
      chk("rst_mid_grant", grant, 0);
      chk("rst_mid_cnt0", pkt_cnt0, 0);
      chk("rst_mid_cnt1", pkt_cnt1, 0);
      clear_tb();
      @(negedge clk);
      reset_n = 1'b1;
      gen_pkt(0, 2);
      run_until_done("rst_mid_fresh", 50);
      chk("rst_mid_fresh_pkt", sop_log.size(), 1);
      chk("rst_mid_fresh_cnt0", pkt_cnt0, exp_cnt(0));

      // counter wrap at 2**CW
      do_reset();
      for (int i = 0; i < (1 << CW) - 1; i++) gen_pkt(0, 1);
      run_until_done("wrap_fill", (1 << CW) * 4);
      chk("wrap_max", pkt_cnt0, exp_cnt(0));
      gen_pkt(0, 1);
      run_until_done("wrap_roll", 20);
      chk("wrap_zero", pkt_cnt0, exp_cnt(0));
      gen_pkt(0, 1);
      run_until_done("wrap_one", 20);
      chk("wrap_one", pkt_cnt0, exp_cnt(0));

      // randomized traffic, gaps, back-pressure and enable
      do_reset();
      gap_en = 1; or_mode = 1; en_rand = 1;
      for (int i = 0; i < 40; i++) gen_pkt(int'($urandom_range(0, 1)), int'($urandom_range(1, 6)));
      run_until_done("rand_drain", 3000);
      chk("rand_pkts", sop_log.size(), 40);
      chk("rand_cnt0", pkt_cnt0, exp_cnt(0));
      chk("rand_cnt1", pkt_cnt1, exp_cnt(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
